// File: rtl/archer_attack_if.sv
// Signal bundle between the mouse/game-state logic and the archer attack sequencer.
// The master side drives the inputs; the slave side is the sequencer itself.
interface archer_attack_if;
    logic        mouse_clicked;
    logic [1:0]  game_active;
    logic        vblnk;
    logic        wpn_visible;
    logic [11:0] anim_x_offset;
    logic        arrow_fire;
    logic        busy;

    modport master (
        output mouse_clicked, game_active, vblnk,
        input  wpn_visible, anim_x_offset, arrow_fire, busy
    );

    modport slave (
        input  mouse_clicked, game_active, vblnk,
        output wpn_visible, anim_x_offset, arrow_fire, busy
    );
endinterface

// File: rtl/archer_attack_ctl.sv
// Archer bow-attack sequencer: draw, release, hold, recover, cooldown, stepped by frame ticks.
// Optional ARCHER_AUTOFIRE_EN: a held button re-arms the shot after each cooldown.
module archer_attack_ctl #(
    parameter int unsigned MAX_OFFSET      = 24,
    parameter int unsigned STEP            = 4,
    parameter int unsigned HOLD_FRAMES     = 3,
    parameter int unsigned COOLDOWN_FRAMES = 10
) (
    input  logic           clk,
    input  logic           rst,
    archer_attack_if.slave bus
);

    typedef enum logic [2:0] {
        IDLE     = 3'd0,
        DRAW     = 3'd1,
        HOLD     = 3'd2,
        RECOVER  = 3'd3,
        COOLDOWN = 3'd4
    } state_t;

    localparam logic [11:0] MAX_OFF_C   = 12'(MAX_OFFSET);
    localparam logic [11:0] STEP_C      = 12'(STEP);
    localparam logic [8:0]  HOLD_LAST_C = 9'(HOLD_FRAMES - 1);
    localparam logic [8:0]  COOL_C      = 9'(COOLDOWN_FRAMES);

    state_t      state_r, state_s;
    logic [11:0] offset_r, offset_s;
    logic [7:0]  cnt_r, cnt_s;
    logic        wpn_r, wpn_s;
    logic        fire_r, fire_s;
    logic        busy_r, busy_s;
    logic        vblnk_r;
    logic        mouse_r;

    logic        tick_s;
    logic        click_s;
    logic        active_s;
    logic        start_s;
    logic [12:0] sum_s;
    logic [11:0] diff_s;
    logic [8:0]  cnt_inc_s;

    assign tick_s    = bus.vblnk & ~vblnk_r;
    assign click_s   = bus.mouse_clicked & ~mouse_r;
    assign active_s  = |bus.game_active;
    assign sum_s     = {1'b0, offset_r} + {1'b0, STEP_C};
    assign diff_s    = (offset_r > STEP_C) ? (offset_r - STEP_C) : 12'd0;
    assign cnt_inc_s = {1'b0, cnt_r} + 9'd1;

`ifdef ARCHER_AUTOFIRE_EN
    assign start_s = active_s & bus.mouse_clicked;
`else
    assign start_s = active_s & click_s;
`endif

    // Edge-detect flops for vblnk and the mouse button
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            vblnk_r <= 1'b0;
            mouse_r <= 1'b0;
        end else begin
            vblnk_r <= bus.vblnk;
            mouse_r <= bus.mouse_clicked;
        end
    end

    // State, counter and registered outputs
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state_r  <= IDLE;
            offset_r <= 12'd0;
            cnt_r    <= 8'd0;
            wpn_r    <= 1'b0;
            fire_r   <= 1'b0;
            busy_r   <= 1'b0;
        end else begin
            state_r  <= state_s;
            offset_r <= offset_s;
            cnt_r    <= cnt_s;
            wpn_r    <= wpn_s;
            fire_r   <= fire_s;
            busy_r   <= busy_s;
        end
    end

    // Next-state and next-output logic; abort on inactive game overrides everything
    always_comb begin
        state_s  = state_r;
        offset_s = offset_r;
        cnt_s    = cnt_r;
        wpn_s    = wpn_r;
        fire_s   = 1'b0;
        busy_s   = busy_r;

        if (!active_s) begin
            state_s  = IDLE;
            offset_s = 12'd0;
            cnt_s    = 8'd0;
            wpn_s    = 1'b0;
            busy_s   = 1'b0;
        end else begin
            case (state_r)
                IDLE: begin
                    // A tick coinciding with the start is deliberately dropped
                    offset_s = 12'd0;
                    cnt_s    = 8'd0;
                    if (start_s) begin
                        state_s = DRAW;
                        wpn_s   = 1'b1;
                        busy_s  = 1'b1;
                    end else begin
                        wpn_s   = 1'b0;
                        busy_s  = 1'b0;
                    end
                end
                DRAW: begin
                    if (tick_s) begin
                        if (sum_s >= {1'b0, MAX_OFF_C}) begin
                            offset_s = MAX_OFF_C;
                            fire_s   = 1'b1;
                            state_s  = HOLD;
                            cnt_s    = 8'd0;
                        end else begin
                            offset_s = sum_s[11:0];
                        end
                    end else begin
                        offset_s = offset_r;
                    end
                end
                HOLD: begin
                    if (tick_s) begin
                        if (cnt_inc_s >= HOLD_LAST_C) begin
                            state_s = RECOVER;
                            cnt_s   = 8'd0;
                        end else begin
                            cnt_s   = cnt_inc_s[7:0];
                        end
                    end else begin
                        cnt_s = cnt_r;
                    end
                end
                RECOVER: begin
                    if (tick_s) begin
                        offset_s = diff_s;
                        if (diff_s == 12'd0) begin
                            wpn_s   = 1'b0;
                            state_s = COOLDOWN;
                            cnt_s   = 8'd0;
                        end else begin
                            wpn_s   = 1'b1;
                        end
                    end else begin
                        offset_s = offset_r;
                    end
                end
                COOLDOWN: begin
                    if (tick_s) begin
                        if (cnt_inc_s >= COOL_C) begin
                            state_s = IDLE;
                            busy_s  = 1'b0;
                            cnt_s   = 8'd0;
                        end else begin
                            cnt_s   = cnt_inc_s[7:0];
                        end
                    end else begin
                        cnt_s = cnt_r;
                    end
                end
                default: begin
                    state_s  = IDLE;
                    offset_s = 12'd0;
                    cnt_s    = 8'd0;
                    wpn_s    = 1'b0;
                    busy_s   = 1'b0;
                end
            endcase
        end
    end

    assign bus.wpn_visible   = wpn_r;
    assign bus.anim_x_offset = offset_r;
    assign bus.arrow_fire    = fire_r;
    assign bus.busy          = busy_r;

endmodule

// File: tb/tb_archer_attack_ctl.sv
// Directed bench for archer_attack_ctl: default instance plus a MAX_OFFSET=10 instance.
module tb_archer_attack_ctl;

    logic clk;
    logic rst;

    archer_attack_if if_a ();
    archer_attack_if if_b ();

    archer_attack_ctl dut_a (.clk(clk), .rst(rst), .bus(if_a));
    archer_attack_ctl #(.MAX_OFFSET(10), .STEP(4), .HOLD_FRAMES(3), .COOLDOWN_FRAMES(10))
        dut_b (.clk(clk), .rst(rst), .bus(if_b));

    initial clk = 1'b0;
    always #5 clk = ~clk;

    typedef struct {
        logic        click;
        logic [1:0]  ga;
        logic        tick;
        logic [11:0] off;
        logic        wpn;
        logic        fire;
        logic        busy;
    } vec_t;

    vec_t tbl[$];
    int   n_checks = 0;
    int   n_pass   = 0;
    int   double_fire = 0;
    logic prev_fire_a = 1'b0;
    logic prev_fire_b = 1'b0;

    // Any two consecutive arrow_fire cycles are an error
    always @(negedge clk) begin
        if (if_a.arrow_fire && prev_fire_a) double_fire++;
        if (if_b.arrow_fire && prev_fire_b) double_fire++;
        prev_fire_a = if_a.arrow_fire;
        prev_fire_b = if_b.arrow_fire;
    end

    function automatic vec_t mk(input logic c, input logic [1:0] g, input logic t,
                                input logic [11:0] o, input logic w, input logic f, input logic b);
        vec_t v;
        v.click = c; v.ga = g; v.tick = t; v.off = o; v.wpn = w; v.fire = f; v.busy = b;
        return v;
    endfunction

    function automatic logic [14:0] pack_a();
        return {if_a.anim_x_offset, if_a.wpn_visible, if_a.arrow_fire, if_a.busy};
    endfunction

    function automatic logic [14:0] pack_b();
        return {if_b.anim_x_offset, if_b.wpn_visible, if_b.arrow_fire, if_b.busy};
    endfunction

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act === exp) n_pass++;
        else $display("FAIL %s: got %0h expected %0h", name, act, exp);
    endtask

    task automatic drive(input bit sel_b, input logic c, input logic [1:0] g, input logic t);
        if (sel_b) begin
            if_b.mouse_clicked = c; if_b.game_active = g; if_b.vblnk = t;
            if_a.mouse_clicked = 1'b0; if_a.game_active = 2'd0; if_a.vblnk = 1'b0;
        end else begin
            if_a.mouse_clicked = c; if_a.game_active = g; if_a.vblnk = t;
            if_b.mouse_clicked = 1'b0; if_b.game_active = 2'd0; if_b.vblnk = 1'b0;
        end
    endtask

    // One stimulus cycle, one check, then a quiet cycle so edges re-arm
    task automatic step(input bit sel_b, input vec_t v, input string name);
        drive(sel_b, v.click, v.ga, v.tick);
        @(posedge clk); @(negedge clk);
        chk(name, 32'(sel_b ? pack_b() : pack_a()), 32'({v.off, v.wpn, v.fire, v.busy}));
        drive(sel_b, 1'b0, v.ga, 1'b0);
        @(posedge clk); @(negedge clk);
    endtask

    initial begin
        int fires;
        int first_t;
        int second_t;
        int exp_shots;
        logic exp_busy_end;

        rst = 1'b0;
        drive(1'b0, 1'b0, 2'd0, 1'b0);
        repeat (3) @(negedge clk);
        chk("reset_a", 32'(pack_a()), 32'd0);
        chk("reset_b", 32'(pack_b()), 32'd0);
        rst = 1'b1;
        @(negedge clk);

        // Full shot, cooldown with ignored clicks, click+tick in IDLE, aborts
        tbl.push_back(mk(1'b1, 2'd1, 1'b0, 12'd0,  1'b1, 1'b0, 1'b1));
        tbl.push_back(mk(1'b0, 2'd1, 1'b1, 12'd4,  1'b1, 1'b0, 1'b1));
        tbl.push_back(mk(1'b0, 2'd1, 1'b1, 12'd8,  1'b1, 1'b0, 1'b1));
        tbl.push_back(mk(1'b0, 2'd1, 1'b1, 12'd12, 1'b1, 1'b0, 1'b1));
        tbl.push_back(mk(1'b0, 2'd1, 1'b1, 12'd16, 1'b1, 1'b0, 1'b1));
        tbl.push_back(mk(1'b0, 2'd1, 1'b1, 12'd20, 1'b1, 1'b0, 1'b1));
        tbl.push_back(mk(1'b0, 2'd1, 1'b1, 12'd24, 1'b1, 1'b1, 1'b1));
        tbl.push_back(mk(1'b0, 2'd1, 1'b1, 12'd24, 1'b1, 1'b0, 1'b1));
        tbl.push_back(mk(1'b0, 2'd1, 1'b1, 12'd24, 1'b1, 1'b0, 1'b1));
        tbl.push_back(mk(1'b0, 2'd1, 1'b1, 12'd20, 1'b1, 1'b0, 1'b1));
        tbl.push_back(mk(1'b0, 2'd1, 1'b1, 12'd16, 1'b1, 1'b0, 1'b1));
        tbl.push_back(mk(1'b0, 2'd1, 1'b1, 12'd12, 1'b1, 1'b0, 1'b1));
        tbl.push_back(mk(1'b0, 2'd1, 1'b1, 12'd8,  1'b1, 1'b0, 1'b1));
        tbl.push_back(mk(1'b0, 2'd1, 1'b1, 12'd4,  1'b1, 1'b0, 1'b1));
        tbl.push_back(mk(1'b0, 2'd1, 1'b1, 12'd0,  1'b0, 1'b0, 1'b1));
        tbl.push_back(mk(1'b1, 2'd1, 1'b0, 12'd0,  1'b0, 1'b0, 1'b1));
        for (int i = 1; i <= 9; i++)
            tbl.push_back(mk(logic'(i % 2), 2'd1, 1'b1, 12'd0, 1'b0, 1'b0, 1'b1));
        tbl.push_back(mk(1'b1, 2'd1, 1'b1, 12'd0,  1'b0, 1'b0, 1'b0));
        tbl.push_back(mk(1'b1, 2'd1, 1'b1, 12'd0,  1'b1, 1'b0, 1'b1));
        tbl.push_back(mk(1'b0, 2'd1, 1'b1, 12'd4,  1'b1, 1'b0, 1'b1));
        tbl.push_back(mk(1'b0, 2'd1, 1'b1, 12'd8,  1'b1, 1'b0, 1'b1));
        tbl.push_back(mk(1'b0, 2'd1, 1'b1, 12'd12, 1'b1, 1'b0, 1'b1));
        tbl.push_back(mk(1'b0, 2'd1, 1'b1, 12'd16, 1'b1, 1'b0, 1'b1));
        tbl.push_back(mk(1'b0, 2'd1, 1'b1, 12'd20, 1'b1, 1'b0, 1'b1));
        tbl.push_back(mk(1'b0, 2'd1, 1'b1, 12'd24, 1'b1, 1'b1, 1'b1));
        tbl.push_back(mk(1'b0, 2'd1, 1'b1, 12'd24, 1'b1, 1'b0, 1'b1));
        tbl.push_back(mk(1'b0, 2'd0, 1'b0, 12'd0,  1'b0, 1'b0, 1'b0));
        tbl.push_back(mk(1'b0, 2'd1, 1'b1, 12'd0,  1'b0, 1'b0, 1'b0));
        tbl.push_back(mk(1'b1, 2'd1, 1'b0, 12'd0,  1'b1, 1'b0, 1'b1));
        tbl.push_back(mk(1'b0, 2'd1, 1'b1, 12'd4,  1'b1, 1'b0, 1'b1));
        tbl.push_back(mk(1'b0, 2'd0, 1'b1, 12'd0,  1'b0, 1'b0, 1'b0));
        tbl.push_back(mk(1'b1, 2'd2, 1'b0, 12'd0,  1'b1, 1'b0, 1'b1));
        tbl.push_back(mk(1'b0, 2'd0, 1'b0, 12'd0,  1'b0, 1'b0, 1'b0));

        foreach (tbl[i]) step(1'b0, tbl[i], $sformatf("vec%0d", i));

        // Asynchronous reset in the middle of a draw
        step(1'b0, mk(1'b1, 2'd1, 1'b0, 12'd0,  1'b1, 1'b0, 1'b1), "rst_seq_click");
        step(1'b0, mk(1'b0, 2'd1, 1'b1, 12'd4,  1'b1, 1'b0, 1'b1), "rst_seq_t1");
        step(1'b0, mk(1'b0, 2'd1, 1'b1, 12'd8,  1'b1, 1'b0, 1'b1), "rst_seq_t2");
        step(1'b0, mk(1'b0, 2'd1, 1'b1, 12'd12, 1'b1, 1'b0, 1'b1), "rst_seq_t3");
        #2 rst = 1'b0;
        #1 chk("rst_async", 32'(pack_a()), 32'd0);
        @(negedge clk);
        rst = 1'b1;
        step(1'b0, mk(1'b0, 2'd1, 1'b1, 12'd0, 1'b0, 1'b0, 1'b0), "rst_idle_tick");
        step(1'b0, mk(1'b1, 2'd1, 1'b0, 12'd0, 1'b1, 1'b0, 1'b1), "rst_restart");
        step(1'b0, mk(1'b0, 2'd0, 1'b0, 12'd0, 1'b0, 1'b0, 1'b0), "rst_abort");

        // Saturating draw with MAX_OFFSET=10
        step(1'b1, mk(1'b1, 2'd1, 1'b0, 12'd0,  1'b1, 1'b0, 1'b1), "b_click");
        step(1'b1, mk(1'b0, 2'd1, 1'b1, 12'd4,  1'b1, 1'b0, 1'b1), "b_t1");
        step(1'b1, mk(1'b0, 2'd1, 1'b1, 12'd8,  1'b1, 1'b0, 1'b1), "b_t2");
        step(1'b1, mk(1'b0, 2'd1, 1'b1, 12'd10, 1'b1, 1'b1, 1'b1), "b_t3_fire");
        step(1'b1, mk(1'b0, 2'd1, 1'b1, 12'd10, 1'b1, 1'b0, 1'b1), "b_hold1");
        step(1'b1, mk(1'b0, 2'd1, 1'b1, 12'd10, 1'b1, 1'b0, 1'b1), "b_hold2");
        step(1'b1, mk(1'b0, 2'd1, 1'b1, 12'd6,  1'b1, 1'b0, 1'b1), "b_rec1");
        step(1'b1, mk(1'b0, 2'd1, 1'b1, 12'd2,  1'b1, 1'b0, 1'b1), "b_rec2");
        step(1'b1, mk(1'b0, 2'd1, 1'b1, 12'd0,  1'b0, 1'b0, 1'b1), "b_rec3");

        // Button held for 40 ticks
        fires = 0; first_t = 0; second_t = 0;
        drive(1'b0, 1'b1, 2'd1, 1'b0);
        @(posedge clk); @(negedge clk);
        for (int t = 1; t <= 40; t++) begin
            if_a.vblnk = 1'b1;
            @(posedge clk); @(negedge clk);
            if (if_a.arrow_fire) begin
                fires++;
                if (fires == 1) first_t = t;
                else if (fires == 2) second_t = t;
            end
            if_a.vblnk = 1'b0;
            @(posedge clk); @(negedge clk);
        end
`ifdef ARCHER_AUTOFIRE_EN
        exp_shots = 2;
        exp_busy_end = 1'b1;
        chk("hold_second_fire", 32'(second_t), 32'd30);
`else
        exp_shots = 1;
        exp_busy_end = 1'b0;
`endif
        chk("hold_shots", 32'(fires), 32'(exp_shots));
        chk("hold_first_fire", 32'(first_t), 32'd6);
        chk("hold_end_busy", 32'(if_a.busy), 32'(exp_busy_end));
        drive(1'b0, 1'b0, 2'd0, 1'b0);
        @(posedge clk); @(negedge clk);

        chk("fire_single_cycle", 32'(double_fire), 32'd0);

        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule
